// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared types and helpers for the parity_stream block.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Widest word the helper function accepts; narrower words are zero-extended,
    // which leaves the reduction XOR unchanged.
    localparam int c_MAX_WIDTH = 64;

    // Frame-tracking states of the stream accumulator.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Reduction XOR of a word (1 = odd number of set bits).
    function automatic logic word_parity(input logic [c_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_word.sv
`default_nettype none
// ============================================================================
// Module      : parity_word
// Description : WIDTH-input XOR tree; the generalised 3-input parity gate.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    // Reduction XOR; synthesis balances this into a log-depth tree.
    assign parity = ^data;

endmodule
`default_nettype wire

// File: rtl/parity_stream.sv
`default_nettype none
// ============================================================================
// Module      : parity_stream
// Description : Accumulates XOR parity over valid/ready framed word streams
//               and reports parity, word count, overflow and check result.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_stream
    import parity_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MAXLEN = 16,
    parameter int CNT_W  = $clog2(MAXLEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd,
    input  logic             check_en,
    input  logic             check_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow,
    output logic             out_error
);

    localparam logic [CNT_W-1:0] c_MAXLEN = CNT_W'(MAXLEN);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    state_t           r_state;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_odd;
    logic             r_out_valid;
    logic             r_out_parity;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_overflow;
    logic             r_out_error;

    logic             w_wpar;
    logic             w_accept;
    logic             w_first;
    logic             w_acc_next;
    logic             w_odd_eff;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic             w_par_final;

    parity_word #(
        .WIDTH (WIDTH)
    ) u_parity_word (
        .data   (in_data),
        .parity (w_wpar)
    );

    assign in_ready = (r_state != HOLD) && !reset;
    assign w_accept = in_valid && in_ready;
    assign w_first  = (r_state == IDLE);

    // Next accumulator/counter values for an accepted word; the first word of
    // a frame restarts them and supplies the parity mode directly.
    always_comb begin
        w_acc_next  = w_first ? w_wpar : (r_acc ^ w_wpar);
        w_odd_eff   = w_first ? odd : r_odd;
        w_cnt_next  = r_cnt;
        w_ovf_next  = r_ovf;
        if (w_first) begin
            w_cnt_next = c_ONE;
            w_ovf_next = 1'b0;
        end else if (r_cnt < c_MAXLEN) begin
            w_cnt_next = r_cnt + c_ONE;
        end else begin
            w_ovf_next = 1'b1;
        end
        w_par_final = w_acc_next ^ w_odd_eff;
    end

    // Frame FSM with accumulator, counter and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_acc          <= 1'b0;
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            r_odd          <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_parity   <= 1'b0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
            r_out_error    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        r_ovf <= w_ovf_next;
                        r_odd <= w_odd_eff;
                        if (in_last) begin
                            r_state        <= HOLD;
                            r_out_valid    <= 1'b1;
                            r_out_parity   <= w_par_final;
                            r_out_count    <= w_cnt_next;
                            r_out_overflow <= w_ovf_next;
                            r_out_error    <= check_en && (check_bit != w_par_final);
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Result stays put until the consumer takes it.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_parity   = r_out_parity;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_overflow;
    assign out_error    = r_out_error;

endmodule
`default_nettype wire
